// File: rtl/bench_timer_array_if.sv
// Channel control and readout bundle for the benchmark timer array.
// The master drives enables, clears and lap strobes. The slave returns the BCD counts and flags.
interface bench_timer_array_if #(
    parameter int NUM_CH     = 2,
    parameter int NUM_DIGITS = 4
);
    logic [NUM_CH-1:0]              ena;
    logic [NUM_CH-1:0]              clr;
    logic [NUM_CH-1:0]              lap;
    logic [NUM_CH*NUM_DIGITS*4-1:0] count_bcd;
    logic [NUM_CH*NUM_DIGITS*4-1:0] lap_bcd;
    logic [NUM_CH-1:0]              ovf;
    logic [NUM_CH-1:0]              tick;

    modport master (
        output ena, clr, lap,
        input  count_bcd, lap_bcd, ovf, tick
    );

    modport slave (
        input  ena, clr, lap,
        output count_bcd, lap_bcd, ovf, tick
    );
endinterface

// File: rtl/bench_timer_array.sv
// Multi-channel decimal benchmark timer: each channel counts TICK_DIV enabled cycles per LSD step
// into a BCD counter, with lap capture and a sticky overflow flag.
module bench_timer_array #(
    parameter int NUM_CH     = 2,
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100000,
    parameter int SATURATE   = 0
) (
    input  logic               CLK100MHZ,
    input  logic               btn_reset,
    bench_timer_array_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = NUM_DIGITS * 4;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    // Ripple-carry BCD increment; the top bit is the carry out of the most significant digit.
    function automatic logic [CW:0] bcd_inc(input logic [CW-1:0] value);
        logic [CW-1:0] result;
        logic          carry;
        logic [3:0]    digit;
        result = value;
        carry  = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            digit = value[d*4 +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    result[d*4 +: 4] = 4'd0;
                end else begin
                    result[d*4 +: 4] = digit + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return {carry, result};
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PW-1:0] presc_r;
        logic [PW-1:0] presc_nxt_s;
        logic [CW-1:0] count_r;
        logic [CW-1:0] count_nxt_s;
        logic [CW-1:0] lap_r;
        logic [CW-1:0] lap_nxt_s;
        logic          ovf_r;
        logic          ovf_nxt_s;
        logic          tick_r;
        logic          tick_nxt_s;
        logic [CW:0]   inc_s;

        assign inc_s = bcd_inc(count_r);

        // Next-state logic for one channel: clear beats counting; lap samples the pre-edge count.
        always_comb begin
            presc_nxt_s = presc_r;
            count_nxt_s = count_r;
            ovf_nxt_s   = ovf_r;
            tick_nxt_s  = 1'b0;
            if (bus.clr[c]) begin
                presc_nxt_s = '0;
                count_nxt_s = '0;
                ovf_nxt_s   = 1'b0;
            end else if (bus.ena[c]) begin
                if (presc_r == TICK_LAST) begin
                    presc_nxt_s = '0;
                    tick_nxt_s  = 1'b1;
                    if (inc_s[CW]) begin
                        ovf_nxt_s = 1'b1;
                        if (SATURATE != 0) begin
                            count_nxt_s = count_r;
                        end else begin
                            count_nxt_s = inc_s[CW-1:0];
                        end
                    end else begin
                        count_nxt_s = inc_s[CW-1:0];
                    end
                end else begin
                    presc_nxt_s = presc_r + PW'(1);
                end
            end else begin
                presc_nxt_s = presc_r;
            end

            if (bus.lap[c]) begin
                lap_nxt_s = count_r;
            end else begin
                lap_nxt_s = lap_r;
            end
        end

        // Channel state registers; btn_reset overrides every channel input.
        always_ff @(posedge CLK100MHZ) begin
            if (btn_reset) begin
                presc_r <= '0;
                count_r <= '0;
                lap_r   <= '0;
                ovf_r   <= 1'b0;
                tick_r  <= 1'b0;
            end else begin
                presc_r <= presc_nxt_s;
                count_r <= count_nxt_s;
                lap_r   <= lap_nxt_s;
                ovf_r   <= ovf_nxt_s;
                tick_r  <= tick_nxt_s;
            end
        end

        assign bus.count_bcd[c*CW +: CW] = count_r;
        assign bus.lap_bcd[c*CW +: CW]   = lap_r;
        assign bus.ovf[c]                = ovf_r;
        assign bus.tick[c]               = tick_r;
    end
endmodule

// File: tb/tb_bench_timer_array.sv
// Directed bench for bench_timer_array: a wrapping and a saturating instance share one stimulus
// stream and are compared every cycle against an enabled-edge-count model.
module tb_bench_timer_array;
    localparam int NCH = 2;
    localparam int ND  = 4;
    localparam int TD  = 4;

    logic       clk = 1'b0;
    logic       btn_reset;
    logic [1:0] ena_v, clr_v, lap_v;
    int         total = 0;
    int         bad   = 0;
    bit         chk_on = 1'b0;

    bench_timer_array_if #(.NUM_CH(NCH), .NUM_DIGITS(ND)) bus_w ();
    bench_timer_array_if #(.NUM_CH(NCH), .NUM_DIGITS(ND)) bus_s ();

    assign bus_w.ena = ena_v;
    assign bus_w.clr = clr_v;
    assign bus_w.lap = lap_v;
    assign bus_s.ena = ena_v;
    assign bus_s.clr = clr_v;
    assign bus_s.lap = lap_v;

    bench_timer_array #(.NUM_CH(NCH), .NUM_DIGITS(ND), .TICK_DIV(TD), .SATURATE(0)) dut_w (
        .CLK100MHZ(clk), .btn_reset(btn_reset), .bus(bus_w.slave));
    bench_timer_array #(.NUM_CH(NCH), .NUM_DIGITS(ND), .TICK_DIV(TD), .SATURATE(1)) dut_s (
        .CLK100MHZ(clk), .btn_reset(btn_reset), .bus(bus_s.slave));

    always #5 clk = ~clk;

    // Model state: enabled edges since the last clear, captured lap value, tick pulse.
    int en_cnt [2];
    int lap_m  [2][2];
    bit tick_m [2];

    function automatic int model_val(int k, int c);
        int t;
        t = en_cnt[c] / TD;
        if (k == 1) return (t > 9999) ? 9999 : t;
        return t % 10000;
    endfunction

    function automatic bit model_ovf(int c);
        return (en_cnt[c] / TD) >= 10000;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        int          x;
        x = v;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (btn_reset) begin
            for (int c = 0; c < 2; c++) begin
                en_cnt[c] = 0;
                tick_m[c] = 1'b0;
                lap_m[0][c] = 0;
                lap_m[1][c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (lap_v[c]) begin
                    lap_m[0][c] = model_val(0, c);
                    lap_m[1][c] = model_val(1, c);
                end
                if (clr_v[c]) begin
                    en_cnt[c] = 0;
                    tick_m[c] = 1'b0;
                end else if (ena_v[c]) begin
                    en_cnt[c] = en_cnt[c] + 1;
                    tick_m[c] = (en_cnt[c] % TD) == 0;
                end else begin
                    tick_m[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] cnt_of(int k, int c);
        return (k == 0) ? bus_w.count_bcd[c*16 +: 16] : bus_s.count_bcd[c*16 +: 16];
    endfunction

    function automatic logic [15:0] lap_of(int k, int c);
        return (k == 0) ? bus_w.lap_bcd[c*16 +: 16] : bus_s.lap_bcd[c*16 +: 16];
    endfunction

    function automatic logic [15:0] ovf_of(int k, int c);
        return (k == 0) ? 16'(bus_w.ovf[c]) : 16'(bus_s.ovf[c]);
    endfunction

    function automatic logic [15:0] tick_of(int k, int c);
        return (k == 0) ? 16'(bus_w.tick[c]) : 16'(bus_s.tick[c]);
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 2; c++) begin
                    chk($sformatf("model_count k%0d c%0d", k, c), cnt_of(k, c), to_bcd(model_val(k, c)));
                    chk($sformatf("model_lap k%0d c%0d", k, c), lap_of(k, c), to_bcd(lap_m[k][c]));
                    chk($sformatf("model_ovf k%0d c%0d", k, c), ovf_of(k, c), 16'(model_ovf(c)));
                    chk($sformatf("model_tick k%0d c%0d", k, c), tick_of(k, c), 16'(tick_m[c]));
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        btn_reset = 1'b1;
        ena_v = 2'b00;
        clr_v = 2'b00;
        lap_v = 2'b00;
        step(1);
        chk_on = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 2; c++) begin
                chk("reset_count", cnt_of(k, c), 16'h0000);
                chk("reset_lap", lap_of(k, c), 16'h0000);
                chk("reset_ovf", ovf_of(k, c), 16'h0000);
                chk("reset_tick", tick_of(k, c), 16'h0000);
            end
        end
        btn_reset = 1'b0;

        // Basic count
        ena_v = 2'b01;
        step(3);
        chk("pre_first_tick", cnt_of(0, 0), 16'h0000);
        step(1);
        chk("first_tick_count", cnt_of(0, 0), 16'h0001);
        chk("first_tick_pulse", tick_of(0, 0), 16'h0001);
        chk("ch1_idle_count", cnt_of(0, 1), 16'h0000);
        chk("ch1_idle_tick", tick_of(0, 1), 16'h0000);
        step(1);
        chk("tick_one_cycle", tick_of(0, 0), 16'h0000);
        step(35);
        chk("forty_edges", cnt_of(0, 0), 16'h0010);

        // Enable gaps on ch1
        ena_v = 2'b10;
        step(2);
        ena_v = 2'b00;
        step(5);
        chk("gap_hold", cnt_of(0, 1), 16'h0000);
        ena_v = 2'b10;
        step(1);
        chk("gap_third", cnt_of(0, 1), 16'h0000);
        step(1);
        chk("gap_fourth", cnt_of(0, 1), 16'h0001);
        chk("gap_tick", tick_of(0, 1), 16'h0001);
        chk("gap_ch0_unaffected", cnt_of(0, 0), 16'h0010);
        ena_v = 2'b00;

        // Lap coincident with a tick, then clear
        ena_v = 2'b01;
        step(124);
        chk("at_0041", cnt_of(0, 0), 16'h0041);
        step(3);
        lap_v = 2'b01;
        step(1);
        lap_v = 2'b00;
        chk("lap_pre_inc", lap_of(0, 0), 16'h0041);
        chk("lap_count_after", cnt_of(0, 0), 16'h0042);
        ena_v = 2'b00;
        clr_v = 2'b01;
        step(1);
        clr_v = 2'b00;
        chk("clr_count", cnt_of(0, 0), 16'h0000);
        chk("clr_ovf", ovf_of(0, 0), 16'h0000);
        chk("clr_keeps_lap", lap_of(0, 0), 16'h0041);

        // clr beats ena
        clr_v = 2'b10;
        ena_v = 2'b10;
        step(6);
        chk("clr_ena_count", cnt_of(0, 1), 16'h0000);
        chk("clr_ena_tick", tick_of(0, 1), 16'h0000);
        clr_v = 2'b00;
        ena_v = 2'b00;

        // Ripple, wrap and saturate
        ena_v = 2'b01;
        step(400);
        chk("ripple_0100_w", cnt_of(0, 0), 16'h0100);
        chk("ripple_0100_s", cnt_of(1, 0), 16'h0100);
        step(39596);
        chk("at_9999_w", cnt_of(0, 0), 16'h9999);
        chk("no_ovf_yet", ovf_of(0, 0), 16'h0000);
        step(4);
        chk("wrap_count", cnt_of(0, 0), 16'h0000);
        chk("wrap_ovf", ovf_of(0, 0), 16'h0001);
        chk("sat_count", cnt_of(1, 0), 16'h9999);
        chk("sat_ovf", ovf_of(1, 0), 16'h0001);
        chk("sat_tick", tick_of(1, 0), 16'h0001);
        step(8);
        chk("wrap_continue", cnt_of(0, 0), 16'h0002);
        chk("wrap_ovf_sticky", ovf_of(0, 0), 16'h0001);
        chk("sat_hold", cnt_of(1, 0), 16'h9999);

        // Reset mid-count
        ena_v = 2'b11;
        step(6);
        btn_reset = 1'b1;
        step(1);
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 2; c++) begin
                chk("mid_reset_count", cnt_of(k, c), 16'h0000);
                chk("mid_reset_lap", lap_of(k, c), 16'h0000);
                chk("mid_reset_ovf", ovf_of(k, c), 16'h0000);
                chk("mid_reset_tick", tick_of(k, c), 16'h0000);
            end
        end
        btn_reset = 1'b0;
        step(3);
        chk("resume_pre", cnt_of(0, 1), 16'h0000);
        step(1);
        chk("resume_ch0", cnt_of(0, 0), 16'h0001);
        chk("resume_ch1", cnt_of(1, 1), 16'h0001);
        ena_v = 2'b00;
        step(2);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bench_timer_array.md
Name: bench_timer_array

Overview:
Multi-channel decimal benchmark timer. It counts enabled clock cycles in units of TICK_DIV cycles into a per-channel BCD counter, and is used to time FPGA benchmark runs. Channels are fully independent; each has its own enable, clear, lap-capture register and sticky overflow flag. The BCD outputs feed the seven-segment driver or a debug readout.

Parameters:
NUM_CH, 2, number of independent timer channels (1..8)
NUM_DIGITS, 4, BCD digits per channel (1..8)
TICK_DIV, 100000, enabled clock cycles per least-significant-digit increment (>=2); 100000 gives 1 ms at 100 MHz
SATURATE, 0, 0 = wrap all-9s to all-0s; 1 = hold at all-9s

Ports:
CLK100MHZ  in  1  system clock; all logic on rising edge
btn_reset  in  1  synchronous active-high reset
ena  in  NUM_CH  per-channel count enable (level)
clr  in  NUM_CH  per-channel synchronous clear (level)
lap  in  NUM_CH  per-channel lap capture strobe
count_bcd  out  NUM_CH*NUM_DIGITS*4  live counts; channel c digit d at bits [(c*NUM_DIGITS+d)*4 +: 4], d=0 least significant
lap_bcd  out  NUM_CH*NUM_DIGITS*4  captured lap values; same packing
ovf  out  NUM_CH  sticky overflow flag per channel
tick  out  NUM_CH  one-cycle pulse, registered with the LSD increment

Behaviour:
- Reset: btn_reset high at an edge zeroes every prescaler, count_bcd, lap_bcd, ovf and tick. It overrides all other inputs, including mid-count.
- Per-channel priority: btn_reset > clr > (lap, ena). lap is evaluated in parallel with clr/ena.
- Prescaler: width $clog2(TICK_DIV).
  - Increments only while ena[c]=1.
  - Holds its value, and does not reset, while ena[c]=0.
  - When the prescaler is at TICK_DIV-1 with ena[c]=1: prescaler returns to 0 and the BCD increment and tick[c]=1 are registered on that same edge.
  - Result: the first increment appears after exactly TICK_DIV enabled edges, counted cumulatively across gaps in ena.
- tick[c] is 0 on every other cycle.
- BCD increment: ripple carry, digit 9 rolls to 0 and carries into the next digit. All digits update on the same edge, so there is no multi-cycle ripple.
  - Digit values are always 0..9.
  - The design does not produce values 10..15, so no guarding against them is required.
- Overflow, when all digits are 9 and a tick occurs:
  - SATURATE=0: count wraps to all zeros and ovf[c] is set to 1.
  - SATURATE=1: count holds at all 9s and ovf[c] is set to 1. The prescaler keeps cycling and tick still pulses.
- ovf[c] stays set until clr[c] or btn_reset.
- clr[c]=1 zeroes prescaler c, count c, ovf[c] and tick[c]. It does not touch lap_bcd.
  - clr with ena asserted on the same edge: clr wins and the count is 0 after the edge.
- lap[c]=1 at an edge: lap_bcd channel c receives the count_bcd value present before that edge.
  - lap coincident with a tick: the pre-increment value is captured.
  - lap coincident with clr: the pre-clear value is captured.
  - lap held high recaptures on every edge.
- Channels share no state. ena, clr and lap on one channel never affect another channel.
- All outputs are registered. There is no combinational path from input to output.

Test Plan:
All scenarios use TICK_DIV=4, NUM_DIGITS=4, NUM_CH=2.
1. Basic count: btn_reset 1 cycle, then ena=2'b01 for 4 edges -> after 4th edge ch0 count=0001 and tick[0] pulses for 1 cycle. Ch1 remains 0000 with tick[1]=0. After 40 enabled edges, ch0=0010.
2. Enable gaps: ena[1] high 2 edges, low 5 edges, high 2 edges -> ch1 reaches 0001 exactly on the 4th enabled edge and holds 0000 during the gap. Ch0 is unaffected.
3. Ripple and wrap: run ch0 to 0099 plus one tick -> 0100. Run to 9999 plus one tick -> 0000 with ovf[0]=1, and ovf stays 1 through further counting. Repeat with SATURATE=1 -> holds 9999 with ovf[0]=1.
4. Lap: at ch0=0041, with the 4th prescaler edge pending, pulse lap[0] on that edge -> lap_bcd ch0=0041 and count=0042. Then clr[0] -> count 0000, ovf 0, lap_bcd still 0041.
5. Priority: clr[1] and ena[1] both high for 6 edges -> ch1 stays 0000 with no tick. btn_reset mid-count with ena=2'b11 -> all count, lap, ovf and tick are 0 after that edge, and counting resumes from 0 only after btn_reset drops.
